// File: rtl/add_sub_seg_display_pkg.sv
// Shared types and constants for the add/sub result display stage:
// converter states, segment encodings and scan geometry.
package add_sub_disp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    // Segments are {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    localparam int         NUM_DIGITS = 3;
    localparam logic [3:0] ANODE_OFF  = 4'b1111;

endpackage

// File: rtl/add_sub_seg_display_if.sv
// Capture strobe / data from the add/sub stage and the display drive outputs.
interface add_sub_seg_display_if;
    logic [4:0] s;
    logic       sign;
    logic       load;
    logic       busy;
    logic [3:0] an;
    logic [6:0] seg;

    modport master (output s, sign, load, input  busy, an, seg);
    modport slave  (input  s, sign, load, output busy, an, seg);
endinterface

// File: rtl/add_sub_seg_display_seg7_decode.sv
// BCD digit to active-low 7-segment pattern, with blank and minus overrides.
module seg7_decode
    import add_sub_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       minus,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (minus)
            seg = SEG_MINUS;
        else if (!blank && digit <= 4'd9)
            seg = SEG_TABLE[digit];
    end

endmodule

// File: rtl/add_sub_seg_display.sv
// Captures the add/sub magnitude and sign, converts to BCD by shift-add-3 and
// scans a common-anode 7-segment display (ones, tens, sign).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for load; display holds last value
//   CONVERT | one adjust+shift per cycle, NUM_BITS cycles
//   UPDATE  | copy BCD and sign to the display registers, drop busy
module add_sub_seg_display
    import add_sub_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int NUM_BITS    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    add_sub_seg_display_if.slave  bus
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    state_t                state, state_n;
    logic [NUM_BITS-1:0]   shreg, shreg_n;
    logic [7:0]            bcd, bcd_n, adj;
    logic [2:0]            cnt, cnt_n;
    logic                  cap_sign, cap_sign_n;
    logic [3:0]            tens, tens_n, ones, ones_n;
    logic                  dsign, dsign_n;

    logic [RW-1:0]         rcnt, rcnt_n;
    logic [1:0]            idx, idx_n;
    logic [3:0]            dig;
    logic                  blank, minus;
    logic [6:0]            seg_d;
    logic [3:0]            an_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bcd      <= '0;
            cnt      <= '0;
            cap_sign <= 1'b0;
            tens     <= '0;
            ones     <= '0;
            dsign    <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bcd      <= bcd_n;
            cnt      <= cnt_n;
            cap_sign <= cap_sign_n;
            tens     <= tens_n;
            ones     <= ones_n;
            dsign    <= dsign_n;
            bus.busy <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bcd_n      = bcd;
        cnt_n      = cnt;
        cap_sign_n = cap_sign;
        tens_n     = tens;
        ones_n     = ones;
        dsign_n    = dsign;
        adj        = bcd;
        case (state)
            IDLE: begin
                if (bus.load) begin
                    shreg_n    = bus.s;
                    cap_sign_n = bus.sign;
                    bcd_n      = '0;
                    cnt_n      = '0;
                    state_n    = CONVERT;
                end
            end
            CONVERT: begin
                if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
                if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
                bcd_n   = {adj[6:0], shreg[NUM_BITS-1]};
                shreg_n = shreg << 1;
                cnt_n   = cnt + 3'd1;
                if (cnt == 3'(NUM_BITS - 1))
                    state_n = UPDATE;
            end
            UPDATE: begin
                tens_n  = bcd[7:4];
                ones_n  = bcd[3:0];
                dsign_n = cap_sign;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        rcnt_n = rcnt + 1'b1;
        idx_n  = idx;
        if (rcnt == RW'(REFRESH_DIV - 1)) begin
            rcnt_n = '0;
            idx_n  = (idx == 2'(NUM_DIGITS - 1)) ? 2'd0 : idx + 2'd1;
        end
    end

    // Decode from next-cycle values so seg/an stay registered yet show the
    // new display contents on the same edge the display registers load.
    always_comb begin
        dig   = ones_n;
        blank = 1'b0;
        minus = 1'b0;
        case (idx_n)
            2'd1: begin
                dig   = tens_n;
                blank = (tens_n == 4'd0);
            end
            2'd2: begin
                blank = 1'b1;
                minus = dsign_n && ((tens_n != 4'd0) || (ones_n != 4'd0));
            end
            default: ;
        endcase
        an_d = ANODE_OFF & ~(4'b0001 << idx_n);
    end

    seg7_decode u_dec (
        .digit (dig),
        .blank (blank),
        .minus (minus),
        .seg   (seg_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt    <= '0;
            idx     <= 2'd0;
            bus.an  <= 4'b1110;
            bus.seg <= 7'b1000000;
        end else begin
            rcnt    <= rcnt_n;
            idx     <= idx_n;
            bus.an  <= an_d;
            bus.seg <= seg_d;
        end
    end

endmodule
